// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, framing constants and
// the running frame checksum helper, also used by host-side image packers.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_WRITE   = 3'd5,
        ST_CHECK   = 3'd6
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Byte positions within a frame; words start at FRM_BODY, CHK follows them
    localparam int FRM_SYNC           = 0;
    localparam int FRM_LEN_HI         = 1;
    localparam int FRM_LEN_LO         = 2;
    localparam int FRM_BODY           = 3;
    localparam int FRM_BYTES_PER_WORD = 2;
    localparam int FRM_OVERHEAD       = 4;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/words/CHK frames, writes words into
// instruction memory from address 0 and holds the CPU halted while loading.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W      = 10,
    parameter int         DATA_W      = 16,
    parameter int         MEM_DEPTH   = 1024,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_en,
    output logic              cpu_halt,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [16:0] MAX_LEN      = 17'(MEM_DEPTH);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_e              state_r;
    state_e              state_s;
    logic [7:0]          len_hi_r;
    logic [7:0]          word_hi_r;
    logic [15:0]         remaining_r;
    logic [ADDR_W:0]     addr_r;
    logic [7:0]          chk_r;
    logic [15:0]         timer_r;
    logic                byte_ready_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_data_r;
    logic                mem_write_en_r;
    logic                cpu_halt_r;
    logic                load_done_r;
    logic                load_err_r;

    logic                accept_s;
    logic [15:0]         len_s;
    logic                len_bad_s;
    logic                timeout_s;

    assign accept_s  = byte_valid && byte_ready_r;
    assign len_s     = {len_hi_r, byte_in};
    assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > MAX_LEN);
    assign timeout_s = (state_r != ST_IDLE) && !accept_s && (timer_r == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a timeout pre-empts whatever the frame parser wanted
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (byte_in == SYNC_BYTE)) state_s = ST_LEN_HI;
                    else                                    state_s = ST_IDLE;
                end
                ST_LEN_HI: begin
                    if (accept_s) state_s = ST_LEN_LO;
                    else          state_s = ST_LEN_HI;
                end
                ST_LEN_LO: begin
                    if (accept_s && len_bad_s) state_s = ST_IDLE;
                    else if (accept_s)         state_s = ST_DATA_HI;
                    else                       state_s = ST_LEN_LO;
                end
                ST_DATA_HI: begin
                    if (accept_s) state_s = ST_DATA_LO;
                    else          state_s = ST_DATA_HI;
                end
                ST_DATA_LO: begin
                    if (accept_s) state_s = ST_WRITE;
                    else          state_s = ST_DATA_LO;
                end
                ST_WRITE: begin
                    if (remaining_r > 16'd1) state_s = ST_DATA_HI;
                    else                     state_s = ST_CHECK;
                end
                ST_CHECK: begin
                    if (accept_s) state_s = ST_IDLE;
                    else          state_s = ST_CHECK;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: counters, checksum, memory port and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi_r       <= 8'd0;
            word_hi_r      <= 8'd0;
            remaining_r    <= 16'd0;
            addr_r         <= '0;
            chk_r          <= 8'd0;
            timer_r        <= 16'd0;
            byte_ready_r   <= 1'b0;
            mem_addr_r     <= '0;
            mem_data_r     <= '0;
            mem_write_en_r <= 1'b0;
            cpu_halt_r     <= 1'b0;
            load_done_r    <= 1'b0;
            load_err_r     <= 1'b0;
        end else begin
            mem_write_en_r <= 1'b0;
            load_done_r    <= 1'b0;
            byte_ready_r   <= (state_s != ST_WRITE);
            if ((state_r == ST_IDLE) || accept_s) begin
                timer_r <= 16'd0;
            end else begin
                timer_r <= timer_r + 16'd1;
            end

            if (timeout_s) begin
                load_err_r <= 1'b1;
                cpu_halt_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s && (byte_in == SYNC_BYTE)) begin
                            cpu_halt_r <= 1'b1;
                            load_err_r <= 1'b0;
                            chk_r      <= 8'd0;
                            addr_r     <= '0;
                        end
                    end
                    ST_LEN_HI: begin
                        if (accept_s) begin
                            len_hi_r <= byte_in;
                            chk_r    <= chk_update(chk_r, byte_in);
                        end
                    end
                    ST_LEN_LO: begin
                        if (accept_s) begin
                            chk_r       <= chk_update(chk_r, byte_in);
                            remaining_r <= len_s;
                            if (len_bad_s) begin
                                load_err_r <= 1'b1;
                                cpu_halt_r <= 1'b0;
                            end
                        end
                    end
                    ST_DATA_HI: begin
                        if (accept_s) begin
                            word_hi_r <= byte_in;
                            chk_r     <= chk_update(chk_r, byte_in);
                        end
                    end
                    ST_DATA_LO: begin
                        // Address MSB set would mean running past the memory; never strobe then
                        if (accept_s) begin
                            chk_r          <= chk_update(chk_r, byte_in);
                            mem_data_r     <= DATA_W'({word_hi_r, byte_in});
                            mem_addr_r     <= addr_r[ADDR_W-1:0];
                            mem_write_en_r <= !addr_r[ADDR_W];
                        end
                    end
                    ST_WRITE: begin
                        addr_r      <= addr_r + 1'b1;
                        remaining_r <= remaining_r - 16'd1;
                    end
                    ST_CHECK: begin
                        if (accept_s) begin
                            if (byte_in == chk_r) begin
                                load_done_r <= 1'b1;
                                cpu_halt_r  <= 1'b0;
                            end else begin
                                load_err_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        load_err_r <= 1'b1;
                        cpu_halt_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign byte_ready   = byte_ready_r;
    assign mem_addr     = mem_addr_r;
    assign mem_data     = mem_data_r;
    assign mem_write_en = mem_write_en_r;
    assign cpu_halt     = cpu_halt_r;
    assign load_done    = load_done_r;
    assign load_err     = load_err_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives framed images byte by byte and
// checks memory writes, halt/done/error flags against hand-computed values.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int TIMEOUT_CYC = 65535;
    localparam int DEPTH       = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_write_en;
    logic        cpu_halt;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W(10), .DATA_W(16), .MEM_DEPTH(DEPTH),
        .SYNC_BYTE(SYNC_BYTE_DEF), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_write_en(mem_write_en), .cpu_halt(cpu_halt),
        .load_done(load_done), .load_err(load_err)
    );

    // Instruction memory model plus write and done-pulse counters
    logic [15:0] mem [0:DEPTH-1];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr] <= mem_data;
            wr_cnt        <= wr_cnt + 1;
        end
        if (load_done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] words [0:DEPTH-1];

    // Drive one byte at the falling edge and hold it until the loader takes it
    task automatic send_byte(input logic [7:0] b, input bit jitter);
        int  n;
        bit  ok;
        if (jitter && ($urandom_range(0, 1) == 1)) begin
            byte_valid = 1'b0;
            byte_in    = SYNC_BYTE_DEF;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        forever begin
            ok = byte_ready;
            @(negedge clk);
            if (ok) break;
            n++;
            if (n > 20) begin
                check("handshake_wait", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] frame_chk(input int n);
        logic [15:0] len;
        logic [7:0]  c;
        len = 16'(n);
        c   = len[15:8] ^ len[7:0];
        for (int i = 0; i < n; i++) c = c ^ words[i][15:8] ^ words[i][7:0];
        return c;
    endfunction

    task automatic send_frame(input int n, input logic [7:0] chk, input bit jitter);
        logic [15:0] len;
        len = 16'(n);
        send_byte(SYNC_BYTE_DEF, jitter);
        send_byte(len[15:8], jitter);
        send_byte(len[7:0], jitter);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], jitter);
            send_byte(words[i][7:0], jitter);
        end
        send_byte(chk, jitter);
        idle(2);
    endtask

    int wr0, done0, bad;

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {21'd0, byte_ready, mem_write_en, cpu_halt, load_done, load_err}, 32'd0);
        check("reset_addr_data", {6'd0, mem_addr, mem_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Good frame; CHK = 00^02^12^34^AB^CD = 42
        wr0 = wr_cnt; done0 = done_cnt;
        send_byte(8'hA5, 1'b0);
        check("halt_after_sync", 32'(cpu_halt), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("write_strobe", {mem_write_en, byte_ready, 4'd0, mem_addr, mem_data}, {1'b1, 1'b0, 4'd0, 10'd0, 16'h1234});
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'h42, 1'b0);
        idle(2);
        check("good_writes", 32'(wr_cnt - wr0), 32'd2);
        check("good_mem0", 32'(mem[0]), 32'h1234);
        check("good_mem1", 32'(mem[1]), 32'hABCD);
        check("good_done", 32'(done_cnt - done0), 32'd1);
        check("good_halt_err", {cpu_halt, load_err}, 32'd0);
        check("idle_hold_addr", {6'd0, mem_addr, mem_data}, {6'd0, 10'd1, 16'hABCD});

        // Same frame, wrong checksum
        wr0 = wr_cnt; done0 = done_cnt;
        words[0] = 16'h1234; words[1] = 16'hABCD;
        send_frame(2, 8'h41, 1'b0);
        check("badchk_writes", 32'(wr_cnt - wr0), 32'd2);
        check("badchk_flags", {cpu_halt, load_err}, 32'd3);
        check("badchk_done", 32'(done_cnt - done0), 32'd0);

        // Zero length
        wr0 = wr_cnt;
        send_byte(8'hA5, 1'b0);
        check("sync_clears_err", 32'(load_err), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(2);
        check("len0_flags", {byte_ready, cpu_halt, load_err}, 32'b101);
        // Length 1025 exceeds depth
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(2);
        check("len1025_flags", {byte_ready, cpu_halt, load_err}, 32'b101);
        check("badlen_writes", 32'(wr_cnt - wr0), 32'd0);

        // Garbage ahead of SYNC and a ragged byte_valid
        wr0 = wr_cnt; done0 = done_cnt;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("garbage_ignored", {cpu_halt, load_err}, 32'b01);
        words[0] = 16'h1234; words[1] = 16'hABCD;
        send_frame(2, 8'h42, 1'b1);
        check("jitter_writes", 32'(wr_cnt - wr0), 32'd2);
        check("jitter_mem", {mem[0], mem[1]}, 32'h1234ABCD);
        check("jitter_done", 32'(done_cnt - done0), 32'd1);
        check("jitter_flags", {cpu_halt, load_err}, 32'd0);

        // SYNC value inside the body is data; CHK = 00^01^A5^5A = FE
        done0 = done_cnt;
        words[0] = 16'hA55A;
        send_frame(1, 8'hFE, 1'b0);
        check("sync_as_data", 32'(mem[0]), 32'hA55A);
        check("sync_as_data_done", {28'(done_cnt - done0), 1'b0, cpu_halt, load_err}, {28'd1, 3'd0});

        // Stall after the first W_HI until timeout
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h77, 1'b0);
        idle(TIMEOUT_CYC - 2);
        check("pre_timeout", {cpu_halt, load_err}, 32'b10);
        idle(3);
        check("timeout_flags", {cpu_halt, load_err}, 32'b01);
        wr0 = wr_cnt; done0 = done_cnt;
        words[0] = 16'h0F0F; words[1] = 16'hBEEF;
        send_frame(2, frame_chk(2), 1'b0);
        check("after_timeout_mem", {mem[0], mem[1]}, 32'h0F0FBEEF);
        check("after_timeout_flags", {28'(done_cnt - done0), 1'b0, cpu_halt, load_err}, {28'd1, 3'd0});

        // Reset during word 2 of a full-depth frame
        for (int i = 0; i < DEPTH; i++) words[i] = 16'h5A00 ^ 16'(i * 7);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send_byte(words[i][15:8], 1'b0);
            send_byte(words[i][7:0], 1'b0);
        end
        send_byte(words[2][15:8], 1'b0);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_flags", {21'd0, byte_ready, mem_write_en, cpu_halt, load_done, load_err}, 32'd0);
        check("midframe_reset_port", {6'd0, mem_addr, mem_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) words[i] = 16'hC300 ^ 16'(i * 13);
        wr0 = wr_cnt; done0 = done_cnt;
        send_frame(DEPTH, frame_chk(DEPTH), 1'b0);
        check("full_writes", 32'(wr_cnt - wr0), 32'(DEPTH));
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== words[i]) bad++;
        check("full_contents", 32'(bad), 32'd0);
        check("full_first_last", {mem[0], mem[DEPTH-1]}, {16'hC300, 16'hC300 ^ 16'(1023 * 13)});
        check("full_done", {28'(done_cnt - done0), 1'b0, cpu_halt, load_err}, {28'd1, 3'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
